// File: rtl/present_pkg.sv
// Shared constants and types for the PRESENT-80 decryption controller.
package present_pkg;

    localparam int unsigned NR_ROUNDS = 32;
    localparam int unsigned KEY_W     = 80;
    localparam int unsigned BLK_W     = 64;
    localparam int unsigned BUS_W     = 80;

    // Decoder load-control encodings driven on dec_pl.
    localparam logic [1:0] PL_RUN = 2'b00;
    localparam logic [1:0] PL_BLK = 2'b01;
    localparam logic [1:0] PL_KEY = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        KEYLD,
        EXPAND,
        BLKLD,
        RUN,
        RESP
    } ctrl_state_t;

endpackage

// File: rtl/present_dec_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The last-served pointer is updated on
// grant_done; the grant already honours that update in the same cycle so
// a new job can be granted on the edge that retires the previous one.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_done,
    input  logic       done_ch,
    output logic [1:0] grant
);

    logic last;
    logic last_eff;

    // Last-served pointer; channel 1 after reset so channel 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (grant_done) begin
            last <= done_ch;
        end
    end

    // Grant the requester not served last when both request.
    always_comb begin
        last_eff = grant_done ? done_ch : last;
        grant    = '0;
        if (req == 2'b11) begin
            grant = last_eff ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/present_dec_ctrl.sv
// Job sequencer and two-channel arbiter in front of a single PRESENT-80
// decoder: drives the pl/in_text load protocol and captures the plaintext.
module present_dec_ctrl
    import present_pkg::*;
#(
    parameter int unsigned EXP_CYCLES  = 30,
    parameter int unsigned RUN_TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*KEY_W-1:0]   req_key,
    input  logic [2*BLK_W-1:0]   req_ct,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [BLK_W-1:0]     rsp_pt,
    output logic                 rsp_err,
    output logic                 dec_rst_n,
    output logic [1:0]           dec_pl,
    output logic [BUS_W-1:0]     dec_in,
    input  logic                 dec_done,
    input  logic [BLK_W-1:0]     dec_text
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(EXP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 1);

    ctrl_state_t        state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [KEY_W-1:0]   key_r, key_nx;
    logic [BLK_W-1:0]   ct_r, ct_nx;
    logic               ch_r, ch_nx;
    logic [BLK_W-1:0]   pt_nx;
    logic               err_nx;
    logic [1:0]         pl_nx;
    logic [BUS_W-1:0]   in_nx;
    logic [1:0]         rst_sync;
    logic [1:0]         grant;
    logic               accept_ok;
    logic               rsp_hs;
    logic               job_hs;
    logic [KEY_W-1:0]   sel_key;
    logic [BLK_W-1:0]   sel_ct;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_valid),
        .grant_done (rsp_hs),
        .done_ch    (ch_r),
        .grant      (grant)
    );

    // Decoder reset: asserted with reset, released two edges after it drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign dec_rst_n = rst_sync[1];

    // Handshake decode and per-channel ready/valid steering.
    always_comb begin
        rsp_hs    = (state == RESP) && rsp_ready[ch_r];
        accept_ok = dec_rst_n && ((state == IDLE) || rsp_hs);
        req_ready = accept_ok ? grant : 2'b00;
        job_hs    = |(req_valid & req_ready);
        sel_key   = req_ready[1] ? req_key[2*KEY_W-1:KEY_W] : req_key[KEY_W-1:0];
        sel_ct    = req_ready[1] ? req_ct[2*BLK_W-1:BLK_W]  : req_ct[BLK_W-1:0];
        rsp_valid = 2'b00;
        if (state == RESP) begin
            rsp_valid[ch_r] = 1'b1;
        end
    end

    // Next-state and next-output logic; dec_pl defaults to run so every
    // load code lasts exactly one cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        key_nx   = key_r;
        ct_nx    = ct_r;
        ch_nx    = ch_r;
        pt_nx    = rsp_pt;
        err_nx   = rsp_err;
        pl_nx    = PL_RUN;
        in_nx    = dec_in;
        case (state)
            IDLE: begin
            end
            KEYLD: begin
                state_nx = EXPAND;
                cnt_nx   = '0;
            end
            EXPAND: begin
                if (cnt == EXP_LAST) begin
                    state_nx = BLKLD;
                    pl_nx    = PL_BLK;
                    in_nx    = {{(BUS_W-BLK_W){1'b0}}, ct_r};
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            BLKLD: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
            RUN: begin
                if (dec_done) begin
                    pt_nx    = dec_text;
                    err_nx   = 1'b0;
                    state_nx = RESP;
                    cnt_nx   = '0;
                end else if (cnt == RUN_LAST) begin
                    pt_nx    = '0;
                    err_nx   = 1'b1;
                    state_nx = RESP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // A job handshake can only occur in IDLE or on the edge that retires
        // a result, so the accept path is shared here after the case.
        if (job_hs) begin
            key_nx   = sel_key;
            ct_nx    = sel_ct;
            ch_nx    = req_ready[1];
            state_nx = KEYLD;
            pl_nx    = PL_KEY;
            in_nx    = sel_key;
        end
    end

    // State, job latches and registered decoder/response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            key_r   <= '0;
            ct_r    <= '0;
            ch_r    <= 1'b0;
            rsp_pt  <= '0;
            rsp_err <= 1'b0;
            dec_pl  <= PL_RUN;
            dec_in  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            key_r   <= key_nx;
            ct_r    <= ct_nx;
            ch_r    <= ch_nx;
            rsp_pt  <= pt_nx;
            rsp_err <= err_nx;
            dec_pl  <= pl_nx;
            dec_in  <= in_nx;
        end
    end

endmodule

// File: tb/tb_present_dec_ctrl.sv
// Directed scoreboard bench for present_dec_ctrl with a behavioural decoder.
module tb_present_dec_ctrl;

    localparam int LAT_OK = 63;
    localparam int LAT_TO = 72;

    typedef struct {
        logic        ch;
        logic [63:0] pt;
        logic        err;
        int          due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [159:0] req_key = '0;
    logic [127:0] req_ct = '0;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b11;
    logic [63:0]  rsp_pt;
    logic         rsp_err;
    logic         dec_rst_n;
    logic [1:0]   dec_pl;
    logic [79:0]  dec_in;
    logic         dec_done;
    wire  [63:0]  dec_text;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int rsp_count = 0;
    int rsp_acc_cyc = 0;
    int hs_ch[$];
    int hs_cyc[$];
    exp_t sb[$];
    logic force_low = 1'b0;

    // Behavioural decoder state
    logic [79:0] key_r = '0;
    logic [63:0] ct_r = '0;
    logic        key_ok = 1'b0;
    logic        blk_ok = 1'b0;
    logic        running = 1'b0;
    logic        done_r = 1'b0;
    int          exp_cnt = 0;
    int          run_cnt = 0;
    logic [63:0] stub_pt = '0;

    present_dec_ctrl #(.EXP_CYCLES(30), .RUN_TIMEOUT(40)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_ct    (req_ct),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_pt    (rsp_pt),
        .rsp_err   (rsp_err),
        .dec_rst_n (dec_rst_n),
        .dec_pl    (dec_pl),
        .dec_in    (dec_in),
        .dec_done  (dec_done),
        .dec_text  (dec_text)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Published PRESENT-80 vectors (key, ciphertext) -> plaintext.
    function automatic logic [63:0] ref_pt(input logic [79:0] k, input logic [63:0] c);
        if (k == 80'h0 && c == 64'h5579C1387B228445) return 64'h0000000000000000;
        if (k == 80'h0 && c == 64'hA112FFC72F68417B) return 64'hFFFFFFFFFFFFFFFF;
        if (k == {80{1'b1}} && c == 64'hE72C46C0F5945049) return 64'h0000000000000000;
        if (k == {80{1'b1}} && c == 64'h3333DCD3213210D2) return 64'hFFFFFFFFFFFFFFFF;
        return 64'hBAD0BAD0BAD0BAD0;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    assign dec_done = done_r & ~force_low;
    assign dec_text = dec_done ? stub_pt : 64'bz;

    // Decoder model: samples on the falling edge, needs a fresh key load and
    // at least 30 run cycles of expansion before the block load.
    initial forever begin
        @(negedge clk or negedge dec_rst_n);
        if (!dec_rst_n) begin
            key_ok = 1'b0; blk_ok = 1'b0; running = 1'b0; done_r = 1'b0;
            exp_cnt = 0; run_cnt = 0;
        end else begin
            case (dec_pl)
                2'b10: begin
                    key_r = dec_in; key_ok = 1'b1; exp_cnt = 0;
                    running = 1'b0; done_r = 1'b0;
                end
                2'b01: begin
                    ct_r = dec_in[63:0];
                    blk_ok = key_ok && (exp_cnt >= 30) && (dec_in[79:64] == 16'h0);
                    key_ok = 1'b0; running = 1'b1; run_cnt = 0; done_r = 1'b0;
                end
                default: begin
                    if (key_ok) exp_cnt++;
                    if (running) begin
                        run_cnt++;
                        if (run_cnt == 31) begin
                            done_r = 1'b1;
                            running = 1'b0;
                        end
                    end
                end
            endcase
        end
        stub_pt = blk_ok ? ref_pt(key_r, ct_r) : 64'hBAD0BAD0BAD0BAD0;
    end

    // Protocol checks and scoreboard, sampled on the falling edge.
    initial begin
        logic [1:0] prev_pl = 2'b00;
        logic [1:0] prev_rv = 2'b00;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("pl_not_11", {79'b0, dec_pl == 2'b11}, '0);
                chk("pl_one_cycle", {79'b0, (prev_pl != 2'b00) && (dec_pl != 2'b00)}, '0);
                chk("ready_onehot0", {79'b0, $onehot0(req_ready)}, 80'd1);
                if (rsp_valid != 2'b00 && prev_rv == 2'b00) begin
                    if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
                    else chk("rsp_latency", cyc, sb[0].due);
                end
                if ((rsp_valid & rsp_ready) != 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected_hs", rsp_valid, '0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_chan", rsp_valid, e.ch ? 2'b10 : 2'b01);
                        chk("rsp_pt", rsp_pt, e.pt);
                        chk("rsp_err", rsp_err, e.err);
                    end
                    rsp_count++;
                    rsp_acc_cyc = cyc + 1;
                end
                for (int c = 0; c < 2; c++) begin
                    if (req_valid[c] && req_ready[c]) begin
                        e.ch  = (c == 1);
                        e.err = force_low;
                        e.pt  = force_low ? 64'h0 :
                                (c == 1) ? ref_pt(req_key[159:80], req_ct[127:64])
                                         : ref_pt(req_key[79:0], req_ct[63:0]);
                        e.due = cyc + 1 + (force_low ? LAT_TO : LAT_OK);
                        sb.push_back(e);
                        hs_ch.push_back(c);
                        hs_cyc.push_back(cyc + 1);
                        hs_count++;
                    end
                end
            end
            prev_pl = dec_pl;
            prev_rv = rsp_valid;
        end
    end

    task automatic wait_hs(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (hs_count >= n) break;
        end
        chk("wait_hs", hs_count, n);
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (rsp_count >= n) break;
        end
        chk("wait_rsp", rsp_count, n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, '0);
        chk({tag, "_rsp_valid"}, rsp_valid, '0);
        chk({tag, "_rsp_pt"}, rsp_pt, '0);
        chk({tag, "_rsp_err"}, rsp_err, '0);
        chk({tag, "_dec_pl"}, dec_pl, '0);
        chk({tag, "_dec_in"}, dec_in, '0);
        chk({tag, "_dec_rst_n"}, dec_rst_n, '0);
    endtask

    task automatic release_rst(input string tag);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rstn_edge1"}, dec_rst_n, 1'b0);
        chk({tag, "_ready_edge1"}, req_ready, 2'b00);
        @(posedge clk); #1;
        chk({tag, "_rstn_edge2"}, dec_rst_n, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");

        // Job 1: channel 0, key 0 -> plaintext 0; held off until decoder reset releases
        req_key[79:0] = 80'h0;
        req_ct[63:0]  = 64'h5579C1387B228445;
        req_valid     = 2'b01;
        release_rst("por");
        chk("ready_after_rst", req_ready, 2'b01);
        wait_hs(1, 10);
        req_valid = 2'b00;
        wait_rsp(1);

        // Job 2: channel 1, all-ones key -> all-ones plaintext
        req_key[159:80] = {80{1'b1}};
        req_ct[127:64]  = 64'h3333DCD3213210D2;
        req_valid       = 2'b10;
        wait_hs(2, 10);
        chk("t2_chan", hs_ch[1], 1);
        req_valid = 2'b00;
        wait_rsp(2);

        // Both channels valid, results accepted at once: alternate every 64 cycles
        req_key[79:0]   = 80'h0;
        req_ct[63:0]    = 64'hA112FFC72F68417B;
        req_key[159:80] = {80{1'b1}};
        req_ct[127:64]  = 64'hE72C46C0F5945049;
        req_valid       = 2'b11;
        wait_hs(6, 400);
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) chk("rr_order", hs_ch[2 + i], i % 2);
        for (int i = 0; i < 3; i++) chk("rr_spacing", hs_cyc[3 + i] - hs_cyc[2 + i], 64);
        wait_rsp(6);

        // Result back-pressured for 20 cycles while the other channel waits
        rsp_ready       = 2'b00;
        req_key[79:0]   = 80'h0;
        req_ct[63:0]    = 64'h5579C1387B228445;
        req_key[159:80] = {80{1'b1}};
        req_ct[127:64]  = 64'h3333DCD3213210D2;
        req_valid       = 2'b11;
        wait_hs(7, 10);
        chk("t4_first", hs_ch[6], 0);
        req_valid = 2'b10;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (rsp_valid != 2'b00) break;
        end
        chk("t4_rv", rsp_valid, 2'b01);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("hold_rv", rsp_valid, 2'b01);
            chk("hold_pt", rsp_pt, 64'h0);
            chk("hold_ready", req_ready, 2'b00);
        end
        chk("hold_no_grant", hs_count, 7);
        rsp_ready = 2'b11;
        wait_hs(8, 10);
        chk("t4_second", hs_ch[7], 1);
        chk("t4_grant_at_accept", hs_cyc[7], rsp_acc_cyc);
        req_valid = 2'b00;
        wait_rsp(8);

        // Decoder never signals done: watchdog response
        force_low     = 1'b1;
        req_key[79:0] = {80{1'b1}};
        req_ct[63:0]  = 64'hE72C46C0F5945049;
        req_valid     = 2'b01;
        wait_hs(9, 10);
        req_valid = 2'b00;
        wait_rsp(9);
        force_low = 1'b0;

        // Reset 40 cycles into a job: job dropped, pointer back to channel 0 first
        req_key[159:80] = 80'h0;
        req_ct[127:64]  = 64'hA112FFC72F68417B;
        req_valid       = 2'b10;
        wait_hs(10, 10);
        req_valid = 2'b00;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid");
        sb.delete();
        repeat (2) @(posedge clk);
        release_rst("mid");
        repeat (40) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_count, 9);

        req_key[79:0]   = {80{1'b1}};
        req_ct[63:0]    = 64'h3333DCD3213210D2;
        req_key[159:80] = 80'h0;
        req_ct[127:64]  = 64'h5579C1387B228445;
        req_valid       = 2'b11;
        wait_hs(12, 200);
        req_valid = 2'b00;
        chk("post_rst_first", hs_ch[10], 0);
        chk("post_rst_second", hs_ch[11], 1);
        wait_rsp(11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
